fwd_scoreboard: RTL

Parametrised operand-forwarding scoreboard for the pipelined core. It tracks every in-flight register write from issue to writeback. It supplies each read port with the youngest available value for its source register, or with the register-file value when no write is pending. When the producing value is not yet computed, it raises a load-use style stall. It replaces the single-stage writeback forward with a multi-stage, multi-port, flush-aware block.

---
 rtl/fwd_pkg.sv | 17 +
 rtl/fwd_lookup.sv | 62 ++++++
 rtl/fwd_scoreboard.sv | 113 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and default sizing for the operand-forwarding scoreboard.
package fwd_pkg;

  localparam int unsigned FWD_XLEN  = 32;
  localparam int unsigned FWD_NREG  = 32;
  localparam int unsigned FWD_DEPTH = 3;
  localparam int unsigned FWD_AW    = $clog2(FWD_NREG);

  // One in-flight register write; dvalid marks that data already holds the result.
  typedef struct packed {
    logic              valid;
    logic [FWD_AW-1:0] rd;
    logic              dvalid;
    logic [FWD_XLEN-1:0] data;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Single read-port lookup: youngest matching in-flight write wins, with
// same-cycle result bypass and hazard detection when no value exists yet.
module fwd_lookup #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 3
) (
  input  logic [AW-1:0]         rs,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [DEPTH-1:0]      ent_valid,
  input  logic [DEPTH-1:0]      ent_dvalid,
  input  logic [DEPTH*AW-1:0]   ent_rd,
  input  logic [DEPTH*XLEN-1:0] ent_data,
  input  logic [DEPTH-1:0]      res_valid,
  input  logic [DEPTH*XLEN-1:0] res_data,
  output logic [XLEN-1:0]       data_c,
  output logic                  hit_c,
  output logic                  hazard_c
);

  logic            found;
  logic            sel_dvalid;
  logic            sel_rv;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] sel_rdata;

  // Scan oldest to youngest so the lowest matching stage overrides older ones.
  always_comb begin
    found      = 1'b0;
    sel_dvalid = 1'b0;
    sel_rv     = 1'b0;
    sel_data   = '0;
    sel_rdata  = '0;
    for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
      if (ent_valid[s] && (ent_rd[s*AW +: AW] == rs)) begin
        found      = 1'b1;
        sel_dvalid = ent_dvalid[s];
        sel_data   = ent_data[s*XLEN +: XLEN];
        sel_rv     = res_valid[s];
        sel_rdata  = res_data[s*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    data_c   = rf_data;
    hit_c    = 1'b0;
    hazard_c = 1'b0;
    if (found && (rs != '0)) begin
      if (sel_dvalid) begin
        data_c = sel_data;
        hit_c  = 1'b1;
      end else if (sel_rv) begin
        data_c = sel_rdata;
        hit_c  = 1'b1;
      end else begin
        hazard_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Multi-stage, multi-port operand-forwarding scoreboard: in-flight write
// pipeline, result capture, per-port lookup, load-use stall and stall counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN  = FWD_XLEN,
  parameter int unsigned NREG  = FWD_NREG,
  parameter int unsigned NRP   = 2,
  parameter int unsigned DEPTH = FWD_DEPTH,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  adv,
  input  logic                  flush,
  input  logic                  iss_valid,
  input  logic                  iss_we,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  input  logic [NRP*$clog2(NREG)-1:0] rs,
  input  logic [NRP-1:0]        rs_used,
  input  logic [NRP*XLEN-1:0]   rf_data,
  input  logic [DEPTH-1:0]      res_valid,
  input  logic [DEPTH*XLEN-1:0] res_data,
  output logic [NRP*XLEN-1:0]   fwd_data,
  output logic [NRP-1:0]        fwd_hit,
  output logic                  stall,
  output logic [CNTW-1:0]       stall_cnt
);

  localparam int unsigned AW = $clog2(NREG);

  fwd_entry_t ent [DEPTH];
  fwd_entry_t cap [DEPTH];
  fwd_entry_t new_ent;

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_dvalid;
  logic [DEPTH*AW-1:0]   ent_rd;
  logic [DEPTH*XLEN-1:0] ent_data;
  logic [NRP-1:0]        hazard;
  logic                  issue;
  logic [CNTW-1:0]       cnt;

  // Each entry with its same-cycle result folded in, plus flattened views for lookup.
  always_comb begin
    for (int s = 0; s < int'(DEPTH); s++) begin
      cap[s] = ent[s];
      if (res_valid[s] && ent[s].valid) begin
        cap[s].dvalid = 1'b1;
        cap[s].data   = res_data[s*XLEN +: XLEN];
      end
      ent_valid[s]             = ent[s].valid;
      ent_dvalid[s]            = ent[s].dvalid;
      ent_rd[s*AW +: AW]       = ent[s].rd;
      ent_data[s*XLEN +: XLEN] = ent[s].data;
    end
  end

  for (genvar i = 0; i < int'(NRP); i++) begin : g_port
    fwd_lookup #(
      .XLEN  (XLEN),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_lookup (
      .rs         (rs[i*AW +: AW]),
      .rf_data    (rf_data[i*XLEN +: XLEN]),
      .ent_valid  (ent_valid),
      .ent_dvalid (ent_dvalid),
      .ent_rd     (ent_rd),
      .ent_data   (ent_data),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .data_c     (fwd_data[i*XLEN +: XLEN]),
      .hit_c      (fwd_hit[i]),
      .hazard_c   (hazard[i])
    );
  end

  assign stall = iss_valid & (|(hazard & rs_used));
  assign issue = iss_valid & iss_we & (iss_rd != '0) & ~stall;

  always_comb begin
    new_ent       = '0;
    new_ent.valid = issue;
    new_ent.rd    = iss_rd;
  end

  // Flush beats advance, issue and capture; hold keeps positions but still captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(DEPTH); s++) ent[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < int'(DEPTH); s++) ent[s] <= '0;
    end else if (adv) begin
      ent[0] <= new_ent;
      for (int s = 1; s < int'(DEPTH); s++) ent[s] <= cap[s-1];
    end else begin
      for (int s = 0; s < int'(DEPTH); s++) ent[s] <= cap[s];
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (stall && adv && (cnt != {CNTW{1'b1}})) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  assign stall_cnt = cnt;

endmodule
